// File: rtl/sysid_checker.sv
// ---------------------------------------------------------------------------
// sysid_checker
//
// Avalon-MM read master placed right after the system-ID slave. On a start
// pulse it reads word 0 (system ID), then word 1 (build timestamp), and
// compares both against build-time parameters. The result is held in DONE
// for boot firmware or the reset sequencer to inspect.
//
// Ports
//   clock              in   system clock, rising edge
//   reset              in   synchronous, active-high reset
//   start              in   one-cycle run request (honoured in IDLE/DONE)
//   avm_address        out  word address: 0 = ID, 1 = timestamp
//   avm_read           out  Avalon read strobe
//   avm_waitrequest    in   slave stall
//   avm_readdatavalid  in   response strobe
//   avm_readdata       in   response data (32 bit)
//   busy               out  check in progress
//   done               out  check finished, results valid
//   pass               out  overall verdict (valid while done=1)
//   id_mismatch        out  sticky: ID differed from EXPECTED_ID
//   ts_mismatch        out  sticky: timestamp differed from EXPECTED_TIMESTAMP
//   timeout_err        out  sticky: a read ran out of retries
//   id_value           out  captured ID word
//   ts_value           out  captured timestamp word
//
// Parameters
//   TIMEOUT_CYCLES  2..65535, cycles allowed per transaction attempt
//   MAX_RETRIES     0..15, extra attempts shared by both words in one run
// ---------------------------------------------------------------------------
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5593_CF0E,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 256,
  parameter int unsigned MAX_RETRIES        = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // Terminal count: an attempt spans exactly TIMEOUT_CYCLES cycles, counted
  // from the first cycle in X_REQ (value 0) through TIMEOUT_CYCLES-1.
  localparam logic [15:0] TERM_CNT  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID_REQ,
    S_ID_WAIT,
    S_TS_REQ,
    S_TS_WAIT,
    S_DONE
  } state_e;

  state_e      state_q;
  logic        avm_read_q;
  logic        avm_address_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        id_mismatch_q;
  logic        ts_mismatch_q;
  logic        timeout_err_q;
  logic [31:0] id_value_q;
  logic [31:0] ts_value_q;
  logic [15:0] tmo_cnt_q;
  logic [3:0]  retry_q;

  // Decoded state and next-value helpers
  logic in_req_d;
  logic in_wait_d;
  logic on_id_d;
  logic accept_d;
  logic resp_d;
  logic expire_d;
  logic retry_ok_d;
  logic id_mm_d;
  logic ts_mm_d;
  logic pass_d;

  always_comb begin
    in_req_d   = (state_q == S_ID_REQ)  || (state_q == S_TS_REQ);
    in_wait_d  = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
    on_id_d    = (state_q == S_ID_REQ)  || (state_q == S_ID_WAIT);
    accept_d   = in_req_d && avm_read_q && !avm_waitrequest;
    // readdatavalid only means something while a response is awaited
    resp_d     = in_wait_d && avm_readdatavalid;
    // A response on the terminal-count cycle wins over the timeout.
    expire_d   = (in_req_d || in_wait_d) && (tmo_cnt_q == TERM_CNT) && !resp_d;
    retry_ok_d = (retry_q < RETRY_LIM);
    id_mm_d    = (avm_readdata != EXPECTED_ID);
    ts_mm_d    = (avm_readdata != EXPECTED_TIMESTAMP);
    // Verdict when the timestamp response completes the run; the ID flag
    // is already final at that point.
    pass_d     = !id_mismatch_q && !(CHECK_TIMESTAMP && ts_mm_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_mismatch_q <= 1'b0;
      ts_mismatch_q <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      tmo_cnt_q     <= '0;
      retry_q       <= '0;
    end else if (expire_d) begin
      // Attempt ran out of time. The read strobe is dropped either way; on a
      // retry the re-entered X_REQ spends its first cycle with read low, which
      // gives the one-cycle gap between attempts.
      avm_read_q <= 1'b0;
      tmo_cnt_q  <= '0;
      if (retry_ok_d) begin
        retry_q <= retry_q + 4'd1;
        state_q <= on_id_d ? S_ID_REQ : S_TS_REQ;
      end else begin
        // An ID timeout skips the timestamp read entirely.
        timeout_err_q <= 1'b1;
        pass_q        <= 1'b0;
        busy_q        <= 1'b0;
        done_q        <= 1'b1;
        state_q       <= S_DONE;
      end
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q       <= S_ID_REQ;
            avm_read_q    <= 1'b1;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_mismatch_q <= 1'b0;
            ts_mismatch_q <= 1'b0;
            timeout_err_q <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
            tmo_cnt_q     <= '0;
            retry_q       <= '0;
          end
        end

        S_ID_REQ, S_TS_REQ: begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
          if (!avm_read_q) begin
            // Retry gap cycle is over; present the read again.
            avm_read_q <= 1'b1;
          end else if (accept_d) begin
            avm_read_q <= 1'b0;
            state_q    <= on_id_d ? S_ID_WAIT : S_TS_WAIT;
          end
          // Otherwise stalled: address and read stay as they are.
        end

        S_ID_WAIT: begin
          if (resp_d) begin
            // The timestamp is read even on an ID mismatch so both values
            // are always reported.
            id_value_q    <= avm_readdata;
            id_mismatch_q <= id_mm_d;
            tmo_cnt_q     <= '0;
            avm_read_q    <= 1'b1;
            avm_address_q <= 1'b1;
            state_q       <= S_TS_REQ;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end

        S_TS_WAIT: begin
          if (resp_d) begin
            ts_value_q    <= avm_readdata;
            ts_mismatch_q <= ts_mm_d;
            pass_q        <= pass_d;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mismatch_q;
  assign ts_mismatch = ts_mismatch_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
